mario_motion_ctrl: RTL and testbench
====================================

// Module: mario_motion_ctrl
// PURPOSE
//  Per-frame motion sequencer for the player sprite. Replaces free keycode-driven motion
//  with a GROUNDED/RISING/FALLING state machine, fixed-step gravity, a floor, a ceiling
//  and walls. Clocked by frame_clk (one update per video frame). Feeds MarioX/Y/S to the
//  colour mapper, in the same way the sprite position feeds the renderer today.
// PARAMETERS
//  X_START    10'd320  reset X position (centre)
//  X_MIN      10'd0    left screen edge
//  X_MAX      10'd639  right screen edge
//  Y_MIN      10'd0    top screen edge
//  GROUND_Y   10'd469  floor Y for sprite centre (Y_MAX-10)
//  SIZE       10'd4    sprite half-size; walls/ceiling are offset by SIZE
//  WALK_STEP  10'd2    horizontal pixels per frame
//  JUMP_V     10'd8    initial upward speed magnitude
//  GRAV       10'd1    speed change per frame
//  MAX_FALL   10'd8    downward speed cap
// PORTS
//  frame_clk    in   1   frame-rate clock, posedge active
//  Reset        in   1   asynchronous active-high reset
//  keycode      in   8   USB HID keycode: 0x04 A=left, 0x07 D=right, 0x1A W=jump, other=none
//  MarioX       out  10  sprite centre X
//  MarioY       out  10  sprite centre Y
//  MarioS       out  10  sprite half-size, constant SIZE
//  State        out  2   00 GROUNDED, 01 RISING, 10 FALLING (11 unused)
//  FacingRight  out  1   1 = last horizontal key was D
// BEHAVIOUR
//  Reset (async, any time, incl. mid-jump): MarioX=X_START, MarioY=GROUND_Y, VelY=0,
//   State=GROUNDED, FacingRight=1. All outputs are registered; changes appear the edge after input.
//  VelY is an internal unsigned 10-bit speed magnitude; direction is implied by State.
//  Each position update uses the VelY value held before the edge; the new VelY applies next frame.
//  Horizontal (evaluated every frame, in all states, independent of vertical):
//   0x04: X_next=X-WALK_STEP, FacingRight<=0; if X < X_MIN+SIZE+WALK_STEP then X_next=X_MIN+SIZE.
//   0x07: X_next=X+WALK_STEP, FacingRight<=1; if X+WALK_STEP > X_MAX-SIZE then X_next=X_MAX-SIZE.
//   Any other code: X and FacingRight hold.
//  GROUNDED: keycode==0x1A -> State<=RISING, VelY<=JUMP_V, Y holds this frame. Otherwise Y
//   holds at GROUND_Y.
//  RISING: Y_next=Y-VelY; VelY_next=VelY-GRAV, saturating at 0; if VelY_next==0 -> FALLING.
//   Ceiling: if Y < Y_MIN+SIZE+VelY -> Y_next=Y_MIN+SIZE, VelY<=0, State<=FALLING.
//   Jump key is ignored while RISING.
//  FALLING: if Y+VelY >= GROUND_Y -> Y_next=GROUND_Y, VelY<=0, State<=GROUNDED (landing frame).
//   Otherwise Y_next=Y+VelY and VelY_next=min(VelY+GRAV, MAX_FALL). Jump key is ignored.
//  A jump key held on the landing frame has no effect; the jump starts on the next frame if the
//   key is still held (auto-repeat is allowed).
//  Arithmetic: all comparisons are unsigned 10-bit and written so they never wrap (compare
//   before subtracting). State 11 is illegal and recovers to FALLING with VelY=0.
// TESTING
//  1 Reset -> X=320, Y=469, State=00, Facing=1, MarioS=4; with keycode 0x00 held for 10 frames,
//    all outputs stay the same.
//  2 W for 1 frame, then 0x00 -> State=01 with Y=469. Next 8 frames Y=461,454,448,443,439,436,
//    434,433 and State=10 after the 8th frame. Then 9 frames of fall Y=433,434,436,439,443,448,
//    454,461,469 with State=00 on the last.
//  3 X=320, hold D for 200 frames -> X reaches 635 and stays there, Facing=1. Hold A from X=6
//    -> X=4 and stays 4, Facing=0.
//  4 Hold W continuously -> jump runs exactly as in test 2, lands, and re-jumps on the frame
//    after landing. W pressed during flight does not change VelY.
//  5 Assert Reset at frame 5 of the rise, between clock edges -> outputs take their reset
//    values immediately, without waiting for an edge.
//  6 GROUND_Y=20, JUMP_V=8, start grounded, press W -> Y clamps to 4 on the ceiling, State=10,
//    then falls back to 20.

Source files
------------

// File: rtl/mario_motion_ctrl.sv
// Per-frame player sprite motion: horizontal walking with wall clamps plus a
// GROUNDED/RISING/FALLING vertical state machine with fixed-step gravity, floor and ceiling.
module mario_motion_ctrl #(
  parameter logic [9:0] X_START   = 10'd320,
  parameter logic [9:0] X_MIN     = 10'd0,
  parameter logic [9:0] X_MAX     = 10'd639,
  parameter logic [9:0] Y_MIN     = 10'd0,
  parameter logic [9:0] GROUND_Y  = 10'd469,
  parameter logic [9:0] SIZE      = 10'd4,
  parameter logic [9:0] WALK_STEP = 10'd2,
  parameter logic [9:0] JUMP_V    = 10'd8,
  parameter logic [9:0] GRAV      = 10'd1,
  parameter logic [9:0] MAX_FALL  = 10'd8
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic [9:0] MarioX,
  output logic [9:0] MarioY,
  output logic [9:0] MarioS,
  output logic [1:0] State,
  output logic       FacingRight
);

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_JUMP  = 8'h1A;

  typedef enum logic [1:0] {
    GROUNDED = 2'b00,
    RISING   = 2'b01,
    FALLING  = 2'b10,
    ILLEGAL  = 2'b11
  } state_t;

  state_t     r_state;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic [9:0] r_vel;
  logic       r_facing;

  state_t     w_stateNext;
  logic [9:0] w_xNext;
  logic [9:0] w_yNext;
  logic [9:0] w_velNext;
  logic       w_facingNext;

  // Widened sums so every bound test is done before any subtraction can wrap.
  logic [10:0] w_xRightSum;
  logic [10:0] w_xRightLimit;
  logic [10:0] w_ceilLimit;
  logic [10:0] w_yFallSum;
  logic [10:0] w_velFallSum;

  assign w_xRightSum   = {1'b0, r_x} + {1'b0, WALK_STEP};
  assign w_xRightLimit = {1'b0, X_MAX} - {1'b0, SIZE};
  assign w_ceilLimit   = {1'b0, Y_MIN} + {1'b0, SIZE} + {1'b0, r_vel};
  assign w_yFallSum    = {1'b0, r_y} + {1'b0, r_vel};
  assign w_velFallSum  = {1'b0, r_vel} + {1'b0, GRAV};

  always_comb begin
    w_stateNext  = r_state;
    w_xNext      = r_x;
    w_yNext      = r_y;
    w_velNext    = r_vel;
    w_facingNext = r_facing;

    if (keycode == KEY_LEFT) begin
      w_facingNext = 1'b0;
      if (r_x < X_MIN + SIZE + WALK_STEP) w_xNext = X_MIN + SIZE;
      else                                w_xNext = r_x - WALK_STEP;
    end else if (keycode == KEY_RIGHT) begin
      w_facingNext = 1'b1;
      if (w_xRightSum > w_xRightLimit) w_xNext = X_MAX - SIZE;
      else                             w_xNext = r_x + WALK_STEP;
    end

    case (r_state)
      GROUNDED: begin
        w_yNext   = GROUND_Y;
        w_velNext = '0;
        if (keycode == KEY_JUMP) begin
          w_stateNext = RISING;
          w_velNext   = JUMP_V;
          w_yNext     = r_y;
        end
      end
      RISING: begin
        if ({1'b0, r_y} < w_ceilLimit) begin
          w_yNext     = Y_MIN + SIZE;
          w_velNext   = '0;
          w_stateNext = FALLING;
        end else begin
          w_yNext   = r_y - r_vel;
          w_velNext = (r_vel > GRAV) ? r_vel - GRAV : '0;
          if (r_vel <= GRAV) w_stateNext = FALLING;
        end
      end
      FALLING: begin
        if (w_yFallSum >= {1'b0, GROUND_Y}) begin
          w_yNext     = GROUND_Y;
          w_velNext   = '0;
          w_stateNext = GROUNDED;
        end else begin
          w_yNext   = r_y + r_vel;
          w_velNext = (w_velFallSum >= {1'b0, MAX_FALL}) ? MAX_FALL : r_vel + GRAV;
        end
      end
      default: begin
        w_stateNext = FALLING;
        w_velNext   = '0;
      end
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= GROUNDED;
      r_x      <= X_START;
      r_y      <= GROUND_Y;
      r_vel    <= '0;
      r_facing <= 1'b1;
    end else begin
      r_state  <= w_stateNext;
      r_x      <= w_xNext;
      r_y      <= w_yNext;
      r_vel    <= w_velNext;
      r_facing <= w_facingNext;
    end
  end

  assign MarioX      = r_x;
  assign MarioY      = r_y;
  assign MarioS      = SIZE;
  assign State       = r_state;
  assign FacingRight = r_facing;

endmodule

// File: tb/tb_mario_motion_ctrl.sv
// Directed and randomized checks of mario_motion_ctrl against an integer
// reference model of the walking/jumping rules.
module tb_mario_motion_ctrl;

  logic       frame_clk;
  logic       Reset;
  logic [7:0] keycode;
  logic [7:0] keycode6;
  logic [9:0] MarioX, MarioY, MarioS;
  logic [1:0] State;
  logic       FacingRight;
  logic [9:0] x6, y6, s6;
  logic [1:0] st6;
  logic       f6;

  int checks = 0;
  int errors = 0;

  int mx, my, mv, mst, mfac;

  int riseY[8] = '{461, 454, 448, 443, 439, 436, 434, 433};
  int fallY[9] = '{433, 434, 436, 439, 443, 448, 454, 461, 469};
  int ceilY[10] = '{12, 5, 4, 4, 5, 7, 10, 14, 19, 20};
  int ceilS[10] = '{1, 1, 2, 2, 2, 2, 2, 2, 2, 0};
  logic [7:0] keyPool[6] = '{8'h04, 8'h07, 8'h1A, 8'h00, 8'h1A, 8'h33};

  mario_motion_ctrl dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .MarioX     (MarioX),
    .MarioY     (MarioY),
    .MarioS     (MarioS),
    .State      (State),
    .FacingRight(FacingRight)
  );

  // Low floor so a full-speed jump hits the ceiling.
  mario_motion_ctrl #(.GROUND_Y(10'd20)) dutLow (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode6),
    .MarioX     (x6),
    .MarioY     (y6),
    .MarioS     (s6),
    .State      (st6),
    .FacingRight(f6)
  );

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive a keycode for one frame and sample 1 time unit after the edge.
  task automatic applyStimulus(input logic [7:0] kc);
    keycode = kc;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic pulseReset();
    Reset = 1'b1;
    #3;
    Reset = 1'b0;
    #1;
  endtask

  task automatic modelReset();
    mx = 320; my = 469; mv = 0; mst = 0; mfac = 1;
  endtask

  // Signed-free integer model: positions/speeds as ints, rules applied directly.
  task automatic modelStep(input logic [7:0] kc);
    int ny;
    if (kc == 8'h04) begin
      mfac = 0;
      mx = (mx - 2 < 4) ? 4 : mx - 2;
    end else if (kc == 8'h07) begin
      mfac = 1;
      mx = (mx + 2 > 635) ? 635 : mx + 2;
    end
    if (mst == 0) begin
      if (kc == 8'h1A) begin mst = 1; mv = 8; end
    end else if (mst == 1) begin
      ny = my - mv;
      if (ny < 4) begin my = 4; mv = 0; mst = 2; end
      else begin
        my = ny;
        mv = (mv > 1) ? mv - 1 : 0;
        if (mv == 0) mst = 2;
      end
    end else begin
      if (my + mv >= 469) begin my = 469; mv = 0; mst = 0; end
      else begin
        my = my + mv;
        mv = (mv + 1 > 8) ? 8 : mv + 1;
      end
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".X"}, 16'(MarioX), 16'(mx));
    checkOutput({tag, ".Y"}, 16'(MarioY), 16'(my));
    checkOutput({tag, ".State"}, 16'(State), 16'(mst));
    checkOutput({tag, ".Facing"}, 16'(FacingRight), 16'(mfac));
  endtask

  initial begin
    logic [7:0] kc;
    int runLen;
    Reset = 1'b1;
    keycode = 8'h00;
    keycode6 = 8'h00;
    #12;
    Reset = 1'b0;
    #1;

    // Reset values and idle hold
    checkOutput("reset.X", 16'(MarioX), 16'd320);
    checkOutput("reset.Y", 16'(MarioY), 16'd469);
    checkOutput("reset.State", 16'(State), 16'd0);
    checkOutput("reset.Facing", 16'(FacingRight), 16'd1);
    checkOutput("reset.S", 16'(MarioS), 16'd4);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'h00);
      checkOutput($sformatf("idle%0d.X", i), 16'(MarioX), 16'd320);
      checkOutput($sformatf("idle%0d.Y", i), 16'(MarioY), 16'd469);
      checkOutput($sformatf("idle%0d.State", i), 16'(State), 16'd0);
      checkOutput($sformatf("idle%0d.Facing", i), 16'(FacingRight), 16'd1);
    end

    // Single jump tap
    applyStimulus(8'h1A);
    checkOutput("jump.start.State", 16'(State), 16'd1);
    checkOutput("jump.start.Y", 16'(MarioY), 16'd469);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'h00);
      checkOutput($sformatf("rise%0d.Y", i), 16'(MarioY), 16'(riseY[i]));
      checkOutput($sformatf("rise%0d.State", i), 16'(State), (i == 7) ? 16'd2 : 16'd1);
    end
    for (int i = 0; i < 9; i++) begin
      applyStimulus(8'h00);
      checkOutput($sformatf("fall%0d.Y", i), 16'(MarioY), 16'(fallY[i]));
      checkOutput($sformatf("fall%0d.State", i), 16'(State), (i == 8) ? 16'd0 : 16'd2);
    end

    // Right wall
    pulseReset();
    for (int i = 1; i <= 200; i++) begin
      applyStimulus(8'h07);
      if (i == 157) checkOutput("walkR.157", 16'(MarioX), 16'd634);
    end
    checkOutput("walkR.end.X", 16'(MarioX), 16'd635);
    checkOutput("walkR.end.Facing", 16'(FacingRight), 16'd1);

    // Left wall from X=6
    pulseReset();
    for (int i = 0; i < 157; i++) applyStimulus(8'h04);
    checkOutput("walkL.six", 16'(MarioX), 16'd6);
    applyStimulus(8'h04);
    checkOutput("walkL.clamp", 16'(MarioX), 16'd4);
    for (int i = 0; i < 5; i++) applyStimulus(8'h04);
    checkOutput("walkL.hold.X", 16'(MarioX), 16'd4);
    checkOutput("walkL.hold.Facing", 16'(FacingRight), 16'd0);
    applyStimulus(8'h00);
    checkOutput("walkL.release.Facing", 16'(FacingRight), 16'd0);

    // Jump held continuously: same arc, then re-jump after landing
    pulseReset();
    applyStimulus(8'h1A);
    checkOutput("hold.start.State", 16'(State), 16'd1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'h1A);
      checkOutput($sformatf("holdRise%0d.Y", i), 16'(MarioY), 16'(riseY[i]));
    end
    checkOutput("hold.apex.State", 16'(State), 16'd2);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(8'h1A);
      checkOutput($sformatf("holdFall%0d.Y", i), 16'(MarioY), 16'(fallY[i]));
    end
    checkOutput("hold.land.State", 16'(State), 16'd0);
    applyStimulus(8'h1A);
    checkOutput("hold.rejump.State", 16'(State), 16'd1);
    checkOutput("hold.rejump.Y", 16'(MarioY), 16'd469);

    // Asynchronous reset mid-rise
    pulseReset();
    applyStimulus(8'h1A);
    for (int i = 0; i < 5; i++) applyStimulus(8'h07);
    checkOutput("midrise.Y", 16'(MarioY), 16'(riseY[4]));
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("async.X", 16'(MarioX), 16'd320);
    checkOutput("async.Y", 16'(MarioY), 16'd469);
    checkOutput("async.State", 16'(State), 16'd0);
    checkOutput("async.Facing", 16'(FacingRight), 16'd1);
    #2;
    Reset = 1'b0;
    #1;

    // Ceiling on the low-floor instance
    pulseReset();
    keycode = 8'h00;
    checkOutput("ceil.reset.Y", 16'(y6), 16'd20);
    keycode6 = 8'h1A;
    @(posedge frame_clk); #1;
    checkOutput("ceil.start.State", 16'(st6), 16'd1);
    keycode6 = 8'h00;
    for (int i = 0; i < 10; i++) begin
      @(posedge frame_clk); #1;
      checkOutput($sformatf("ceil%0d.Y", i), 16'(y6), 16'(ceilY[i]));
      checkOutput($sformatf("ceil%0d.State", i), 16'(st6), 16'(ceilS[i]));
    end

    // Randomized runs against the model
    pulseReset();
    modelReset();
    for (int n = 0; n < 500; n += runLen) begin
      kc = keyPool[$urandom_range(0, 5)];
      runLen = $urandom_range(1, 40);
      for (int k = 0; k < runLen; k++) begin
        applyStimulus(kc);
        modelStep(kc);
        checkModel($sformatf("rand%0d", n + k));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
